// File: rtl/solver_pkg.sv
// Shared definitions for the Mandelbrot solver host side: limb-width defaults
// and the feeder state encoding.
package solver_pkg;

  localparam int unsigned LIMB_INDEX_BITS = 6;
  localparam int unsigned LIMB_SIZE_BITS  = 27;
  localparam int unsigned NUM_LIMBS       = 4;

  typedef enum logic [2:0] {
    StLoad,
    StDrain,
    StStart,
    StWait,
    StResult
  } feeder_state_e;

endpackage

// File: rtl/solver_watchdog.sv
// Clearable WAIT-cycle counter. expire is high in the WAIT cycle whose 1-based
// index equals TIMEOUT_CYCLES; a zero limit never expires.
module solver_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit Enabled = (TIMEOUT_CYCLES != 0);

  // Holds the number of WAIT cycles already completed, so the current cycle is cnt_q + 1.
  logic [CntW-1:0] cnt_q;

  assign expire = Enabled && count && (cnt_q == LastCnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/solver_feeder.sv
// Host-side initiator for one Mandelbrot solver: loads a point limb by limb,
// pulses start, waits for completion (or watchdog expiry) and returns the result.
module solver_feeder #(
  parameter int unsigned LIMB_INDEX_BITS = solver_pkg::LIMB_INDEX_BITS,
  parameter int unsigned LIMB_SIZE_BITS  = solver_pkg::LIMB_SIZE_BITS,
  parameter int unsigned NUM_LIMBS       = solver_pkg::NUM_LIMBS,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter int unsigned ID_BITS         = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  in_data,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_limb,
  output logic [LIMB_SIZE_BITS-1:0]  wr_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  iterations,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [LIMB_SIZE_BITS-1:0]  res_iter,
  output logic [ID_BITS-1:0]         res_id,
  output logic                       res_timeout,
  output logic                       busy
);

  import solver_pkg::*;

  localparam int unsigned CntW = LIMB_INDEX_BITS + 1;
  localparam logic [CntW-1:0] NumLimbs = CntW'(NUM_LIMBS);
  localparam logic [CntW-1:0] LastLimb = CntW'(2 * NUM_LIMBS - 1);

  feeder_state_e              state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [ID_BITS-1:0]         id_q, id_d;
  logic [LIMB_SIZE_BITS-1:0]  iter_q, iter_d;
  logic                       timeout_q, timeout_d;
  logic                       out_ready_q;
  logic                       wr_real_q, wr_imag_q;
  logic [LIMB_INDEX_BITS-1:0] wr_limb_q;
  logic [LIMB_SIZE_BITS-1:0]  wr_data_q;

  logic                       accept;
  logic                       is_real;
  logic [CntW-1:0]            limb_idx;
  logic                       done;
  logic                       expire;
  logic                       wd_clear;
  logic                       wd_count;

  assign accept   = (state_q == StLoad) && in_valid;
  assign is_real  = (cnt_q < NumLimbs);
  assign limb_idx = is_real ? cnt_q : (cnt_q - NumLimbs);
  // Edge-based so a level left high by the previous job (or across reset) is ignored.
  assign done     = out_ready && !out_ready_q;

  solver_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clear (wd_clear),
    .count (wd_count),
    .expire(expire)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    wd_clear  = 1'b0;
    wd_count  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastLimb) state_d = StDrain;
        end
      end
      StDrain: state_d = StStart;
      StStart: begin
        wd_clear = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        wd_count = 1'b1;
        // Completion takes priority over a coincident watchdog expiry.
        if (done) begin
          iter_d    = iterations;
          timeout_d = 1'b0;
          state_d   = StResult;
        end else if (expire) begin
          iter_d    = '1;
          timeout_d = 1'b1;
          state_d   = StResult;
        end
      end
      StResult: begin
        if (res_ready) begin
          id_d    = id_q + 1'b1;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      id_q        <= '0;
      iter_q      <= '0;
      timeout_q   <= 1'b0;
      out_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      iter_q      <= iter_d;
      timeout_q   <= timeout_d;
      out_ready_q <= out_ready;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_real_q <= 1'b0;
      wr_imag_q <= 1'b0;
      wr_limb_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_real_q <= accept && is_real;
      wr_imag_q <= accept && !is_real;
      if (accept) begin
        wr_limb_q <= limb_idx[LIMB_INDEX_BITS-1:0];
        wr_data_q <= in_data;
      end
    end
  end

  assign in_ready    = (state_q == StLoad);
  assign start       = (state_q == StStart);
  assign res_valid   = (state_q == StResult);
  assign busy        = !((state_q == StLoad) && (cnt_q == '0));
  assign res_iter    = iter_q;
  assign res_id      = id_q;
  assign res_timeout = timeout_q;
  assign wr_real_en  = wr_real_q;
  assign wr_imag_en  = wr_imag_q;
  assign wr_limb     = wr_limb_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_solver_feeder.sv
// Randomized scoreboard bench for solver_feeder: driver issues jobs and acts as
// the solver, monitor checks writes, start, handshakes and results against queues.
module tb_solver_feeder;

  localparam int NL  = 4;
  localparam int LIB = 6;
  localparam int LSB = 27;
  localparam int T   = 20;
  localparam int IDB = 8;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [LSB-1:0] in_data;
  logic           wr_real_en;
  logic           wr_imag_en;
  logic [LIB-1:0] wr_limb;
  logic [LSB-1:0] wr_data;
  logic           start;
  logic           out_ready;
  logic [LSB-1:0] iterations;
  logic           res_valid;
  logic           res_ready;
  logic [LSB-1:0] res_iter;
  logic [IDB-1:0] res_id;
  logic           res_timeout;
  logic           busy;

  solver_feeder #(
    .LIMB_INDEX_BITS(LIB),
    .LIMB_SIZE_BITS (LSB),
    .NUM_LIMBS      (NL),
    .TIMEOUT_CYCLES (T),
    .ID_BITS        (IDB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wr_real_en (wr_real_en),
    .wr_imag_en (wr_imag_en),
    .wr_limb    (wr_limb),
    .wr_data    (wr_data),
    .start      (start),
    .out_ready  (out_ready),
    .iterations (iterations),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_iter   (res_iter),
    .res_id     (res_id),
    .res_timeout(res_timeout),
    .busy       (busy)
  );

  typedef struct {
    int           due;
    bit           re;
    logic [LIB-1:0] idx;
    logic [LSB-1:0] data;
  } wr_t;

  typedef struct {
    int           due;
    logic [LSB-1:0] iter;
    bit           to;
  } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int             m_acc;
  int             start_due;
  logic [IDB-1:0] exp_id;
  logic           rv_prev;
  logic [35:0]    snap;
  logic [LIB-1:0] last_limb;
  logic [LSB-1:0] last_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      exp_wr.delete();
      exp_res.delete();
      m_acc     = 0;
      start_due = -1;
      exp_id    = '0;
      rv_prev   = 1'b0;
      last_limb = '0;
      last_data = '0;
    end else begin
      chk("in_ready", in_ready, m_acc < 2 * NL);
      chk("busy", busy, m_acc != 0);

      if (wr_real_en || wr_imag_en) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {wr_real_en, wr_imag_en}, 2'b00);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write", {cyc, wr_real_en, wr_imag_en, wr_limb, wr_data},
              {w.due, w.re, !w.re, w.idx, w.data});
        end
        last_limb = wr_limb;
        last_data = wr_data;
      end else begin
        chk("write_hold", {wr_limb, wr_data}, {last_limb, last_data});
        if (exp_wr.size() > 0 && exp_wr[0].due <= cyc) begin
          chk("missing_write", {wr_real_en, wr_imag_en}, {exp_wr[0].re, !exp_wr[0].re});
          void'(exp_wr.pop_front());
        end
      end

      if (in_valid && in_ready && m_acc < 2 * NL) begin
        wr_t w;
        w.due  = cyc + 1;
        w.re   = (m_acc < NL);
        w.idx  = LIB'(m_acc < NL ? m_acc : m_acc - NL);
        w.data = in_data;
        exp_wr.push_back(w);
        m_acc++;
        if (m_acc == 2 * NL) start_due = cyc + 2;
      end

      if (start) begin
        chk("start_cycle", cyc, start_due);
        start_due = -1;
      end else if (start_due >= 0 && cyc > start_due) begin
        chk("missing_start", start, 1'b1);
        start_due = -1;
      end

      if (res_valid) begin
        if (!rv_prev) begin
          if (exp_res.size() == 0) chk("unexpected_result", res_valid, 1'b0);
          else chk("result", {cyc, res_iter, res_id, res_timeout},
                   {exp_res[0].due, exp_res[0].iter, exp_id, exp_res[0].to});
          snap = {res_iter, res_id, res_timeout};
        end else begin
          chk("result_stable", {res_iter, res_id, res_timeout}, snap);
        end
        if (res_ready) begin
          if (exp_res.size() > 0) void'(exp_res.pop_front());
          exp_id++;
          m_acc = 0;
        end
      end else if (exp_res.size() > 0 && cyc > exp_res[0].due) begin
        chk("missing_result", res_valid, 1'b1);
        void'(exp_res.pop_front());
      end
      rv_prev = res_valid && !res_ready;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("reset_outputs",
        {wr_real_en, wr_imag_en, wr_limb, wr_data, start, res_valid, res_iter, res_id,
         res_timeout, busy, in_ready}, 128'd1);
  endtask

  // Called one time unit after a rising edge; asserts reset between edges.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    in_valid  = 1'b0;
    res_ready = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    step();
  endtask

  // lat < 0: the solver never completes. keep_high: out_ready stays high from the
  // previous job and only drops three cycles after start.
  task automatic run_job(input bit fixed, input int gap_max, input int lat, input bit keep_high,
                         input int hold, input int rst_limbs, input int rst_wait);
    logic [LSB-1:0] limbs[2*NL];
    logic [LSB-1:0] iter;
    int t_last, s, u, endc;
    bit ok, got;
    res_t r;
    if (!keep_high) out_ready = 1'b0;
    for (int k = 0; k < 2 * NL; k++) limbs[k] = fixed ? LSB'(k + 1) : LSB'($urandom);
    for (int k = 0; k < 2 * NL; k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        in_valid = 1'b0;
        in_data  = LSB'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_data  = limbs[k];
      ok = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        @(negedge clock);
        if (in_ready) begin
          ok     = 1'b1;
          t_last = cyc;
        end
        step();
      end
      in_valid = 1'b0;
      if (!ok) begin
        chk("accept_timeout", in_ready, 1'b1);
        return;
      end
      if (rst_limbs == k + 1) begin
        pulse_reset();
        return;
      end
    end

    s = t_last + 2;
    if (rst_wait > 0) begin
      while (cyc < s + rst_wait) step();
      pulse_reset();
      return;
    end

    iter = LSB'($urandom);
    if (lat < 0 || lat > T) begin
      u = s + T;
      r.iter = {LSB{1'b1}};
      r.to   = 1'b1;
    end else begin
      u = s + lat;
      r.iter = iter;
      r.to   = 1'b0;
    end
    r.due = u + 1;
    exp_res.push_back(r);

    endc = (lat < 0) ? s + T + 2 : s + lat;
    while (cyc < endc) begin
      step();
      in_valid = 1'($urandom_range(1, 0));
      in_data  = LSB'($urandom);
      if (keep_high && cyc == s + 3) out_ready = 1'b0;
    end
    if (lat >= 0) begin
      out_ready  = 1'b1;
      iterations = iter;
    end
    step();
    iterations = LSB'($urandom);

    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      if (res_valid) got = 1'b1;
      else begin
        in_valid = 1'($urandom_range(1, 0));
        step();
      end
    end
    if (!got) begin
      chk("result_timeout", res_valid, 1'b1);
      return;
    end
    repeat (hold) begin
      in_valid = 1'($urandom_range(1, 0));
      in_data  = LSB'($urandom);
      step();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    iterations = '0;
    res_ready  = 1'b0;
    step();
    check_reset_outputs();
    step();
    #2 reset = 1'b1;
    step();

    // Limbs 1..8 back to back, solver done 10 cycles after start.
    out_ready = 1'b0;
    run_job(1'b1, 0, 10, 1'b0, 0, 0, 0);
    run_job(1'b0, 3, $urandom_range(15, 4), 1'b0, 0, 0, 0);
    // out_ready left high across the job boundary.
    run_job(1'b0, 2, 12, 1'b1, 1, 0, 0);
    // Never completes; result held for five cycles.
    run_job(1'b0, 2, -1, 1'b0, 5, 0, 0);
    // Completion coincides with expiry, then completion one cycle too late.
    run_job(1'b0, 1, T, 1'b0, 0, 0, 0);
    run_job(1'b0, 1, T + 1, 1'b0, 2, 0, 0);

    // Reset mid-LOAD with out_ready high: the level must be ignored afterwards.
    out_ready = 1'b1;
    run_job(1'b0, 1, 10, 1'b1, 0, 3, 0);
    run_job(1'b0, 1, 9, 1'b1, 0, 0, 0);
    // Reset mid-WAIT.
    run_job(1'b0, 1, 10, 1'b0, 0, 0, 6);
    run_job(1'b1, 0, 7, 1'b0, 0, 0, 0);

    for (int j = 0; j < 6; j++) begin
      int lat;
      lat = $urandom_range(T + 4, 5);
      if ($urandom_range(4, 0) == 0) lat = -1;
      run_job(1'b0, 3, lat, 1'($urandom_range(1, 0)), $urandom_range(3, 0), 0, 0);
    end

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
